// File: rtl/wvb_reader_pkg.sv
// Shared types and widths for the round-robin waveform-buffer reader.
//   state_t      : reader FSM states
//   DPRAM_LEN_W  : width of the DPRAM fill length
//   EVT_CNT_W    : width of the completed-event counter
package wvb_reader_pkg;

  localparam int DPRAM_LEN_W = 16;
  localparam int EVT_CNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_WAIT = 3'd1,
    ST_REQ      = 3'd2,
    ST_RUN      = 3'd3,
    ST_BUSY     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/wvb_reader_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req         : per-channel request (eligible) vector
//   last_grant  : channel granted most recently
//   grant_idx   : first requesting channel strictly after last_grant (wraps)
//   grant_valid : any request present
// The request vector is duplicated; the low copy is masked up to and
// including last_grant, so the lowest set bit of the double-width vector is
// the next channel in round-robin order. A single pass resolves the grant no
// matter how many idle channels are skipped.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N; i++) begin
      if (i <= int'(last_grant)) dbl[i] = 1'b0;
    end
    grant_valid = |req;
    grant_idx   = '0;
    // Scan downwards so the lowest set bit wins.
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) grant_idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
    end
  end

endmodule

// File: rtl/wvb_reader_rr.sv
// Multi-channel waveform-buffer reader with round-robin arbitration.
// Picks the next non-empty, enabled channel, pops its header, hands the
// channel to the external read controller and sequences DPRAM fills until the
// event is complete.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   en                         : reader enable (sampled only when idle)
//   chan_mask, hdr_empty       : per-channel eligibility inputs
//   hdr_data, wvb_data         : concatenated per-channel header / waveform words
//   hdr_rdreq                  : registered one-hot header pop to granted channel
//   wvb_rdreq, wvb_rddone      : combinational one-hot demux of rc_* strobes
//   rc_req/rc_idx/rc_ack/...   : read-controller handshake
//   rc_hdr_data, rc_wvb_data   : muxed data of channel rc_idx (2 register stages)
//   dpram_busy/mode/run/len    : DPRAM handshake
//   evt_cnt, stall             : status
module wvb_reader_rr
  import wvb_reader_pkg::*;
#(
  parameter int N_CHANNELS   = 8,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_HDR_WAIT   = 3,
  parameter int P_IDX_WIDTH  = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [N_CHANNELS-1:0]             chan_mask,
  input  logic [N_CHANNELS-1:0]             hdr_empty,
  input  logic [N_CHANNELS*P_HDR_WIDTH-1:0] hdr_data,
  input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
  output logic [N_CHANNELS-1:0]             hdr_rdreq,
  output logic [N_CHANNELS-1:0]             wvb_rdreq,
  output logic [N_CHANNELS-1:0]             wvb_rddone,
  output logic                              rc_req,
  output logic [P_IDX_WIDTH-1:0]            rc_idx,
  input  logic                              rc_ack,
  input  logic                              rc_more,
  input  logic [DPRAM_LEN_W-1:0]            rc_len,
  input  logic                              rc_wvb_rdreq,
  input  logic                              rc_wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]            rc_hdr_data,
  output logic [P_DATA_WIDTH-1:0]           rc_wvb_data,
  input  logic                              dpram_busy,
  input  logic                              dpram_mode,
  output logic                              dpram_run,
  output logic [DPRAM_LEN_W-1:0]            dpram_len,
  output logic [EVT_CNT_W-1:0]              evt_cnt,
  output logic                              stall
);

  localparam int HW_W = $clog2(P_HDR_WAIT) + 1;
  // HDR_WAIT lasts P_HDR_WAIT-1 cycles; rc_req is registered from REQ, which
  // adds the last cycle of the hdr_rdreq -> rc_req distance.
  localparam logic [HW_W-1:0] HW_LAST = HW_W'(P_HDR_WAIT - 2);

  state_t                                    state_q, state_d;
  logic [HW_W-1:0]                           hw_cnt_q, hw_cnt_d;
  logic [P_IDX_WIDTH-1:0]                    rc_idx_q, rc_idx_d;
  logic [P_IDX_WIDTH-1:0]                    last_grant_q, last_grant_d;
  logic                                      rc_req_q, rc_req_d;
  logic                                      dpram_run_q, dpram_run_d;
  logic [DPRAM_LEN_W-1:0]                    dpram_len_q, dpram_len_d;
  logic [EVT_CNT_W-1:0]                      evt_cnt_q, evt_cnt_d;
  logic [N_CHANNELS-1:0]                     hdr_rdreq_q, hdr_rdreq_d;

  logic [N_CHANNELS-1:0][P_HDR_WIDTH-1:0]    hdr_in_q, hdr_in_d;
  logic [N_CHANNELS-1:0][P_DATA_WIDTH-1:0]   wvb_in_q, wvb_in_d;
  logic [P_HDR_WIDTH-1:0]                    rc_hdr_q, rc_hdr_d;
  logic [P_DATA_WIDTH-1:0]                   rc_wvb_q, rc_wvb_d;

  logic [N_CHANNELS-1:0]                     eligible;
  logic [N_CHANNELS-1:0]                     grant_oh;
  logic [N_CHANNELS-1:0]                     idx_oh;
  logic [P_IDX_WIDTH-1:0]                    grant_idx;
  logic                                      grant_valid;

  assign eligible = chan_mask & ~hdr_empty;

  rr_arbiter #(
    .N     (N_CHANNELS),
    .IDX_W (P_IDX_WIDTH)
  ) u_arb (
    .req         (eligible),
    .last_grant  (last_grant_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Per-lane decode of the grant and of the latched channel index.
  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_lane
    assign grant_oh[g]   = (grant_idx == P_IDX_WIDTH'(g));
    assign idx_oh[g]     = (rc_idx_q  == P_IDX_WIDTH'(g));
    assign wvb_rdreq[g]  = rc_wvb_rdreq  & idx_oh[g];
    assign wvb_rddone[g] = rc_wvb_rddone & idx_oh[g];
  end

  // Data path: stage 1 registers all channel inputs, stage 2 registers the
  // word selected by rc_idx.
  always_comb begin
    hdr_in_d = hdr_data;
    wvb_in_d = wvb_data;
    rc_hdr_d = '0;
    rc_wvb_d = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (idx_oh[i]) begin
        rc_hdr_d = hdr_in_q[i];
        rc_wvb_d = wvb_in_q[i];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    hw_cnt_d     = hw_cnt_q;
    rc_idx_d     = rc_idx_q;
    last_grant_d = last_grant_q;
    dpram_len_d  = dpram_len_q;
    evt_cnt_d    = evt_cnt_q;
    rc_req_d     = 1'b0;
    dpram_run_d  = 1'b0;
    hdr_rdreq_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (en && grant_valid && !dpram_busy && !rc_ack) begin
          rc_idx_d    = grant_idx;
          hdr_rdreq_d = grant_oh;
          hw_cnt_d    = '0;
          state_d     = ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: begin
        if (hw_cnt_q >= HW_LAST) state_d  = ST_REQ;
        else                     hw_cnt_d = hw_cnt_q + 1'b1;
      end
      ST_REQ: begin
        // Only an ack to a visible request ends the handshake.
        if (rc_req_q && rc_ack) begin
          dpram_len_d = rc_len;
          state_d     = ST_RUN;
        end else begin
          rc_req_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!dpram_busy) begin
          dpram_run_d = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (dpram_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!dpram_busy) begin
          if (dpram_mode && rc_more) begin
            // Event spills into another DPRAM: same channel, new fill.
            if (!rc_ack) state_d = ST_REQ;
          end else begin
            last_grant_d = rc_idx_q;
            evt_cnt_d    = evt_cnt_q + 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hw_cnt_q     <= '0;
      rc_idx_q     <= '0;
      last_grant_q <= P_IDX_WIDTH'(N_CHANNELS - 1);
      rc_req_q     <= 1'b0;
      dpram_run_q  <= 1'b0;
      dpram_len_q  <= '0;
      evt_cnt_q    <= '0;
      hdr_rdreq_q  <= '0;
      hdr_in_q     <= '0;
      wvb_in_q     <= '0;
      rc_hdr_q     <= '0;
      rc_wvb_q     <= '0;
    end else begin
      state_q      <= state_d;
      hw_cnt_q     <= hw_cnt_d;
      rc_idx_q     <= rc_idx_d;
      last_grant_q <= last_grant_d;
      rc_req_q     <= rc_req_d;
      dpram_run_q  <= dpram_run_d;
      dpram_len_q  <= dpram_len_d;
      evt_cnt_q    <= evt_cnt_d;
      hdr_rdreq_q  <= hdr_rdreq_d;
      hdr_in_q     <= hdr_in_d;
      wvb_in_q     <= wvb_in_d;
      rc_hdr_q     <= rc_hdr_d;
      rc_wvb_q     <= rc_wvb_d;
    end
  end

  assign hdr_rdreq   = hdr_rdreq_q;
  assign rc_req      = rc_req_q;
  assign rc_idx      = rc_idx_q;
  assign rc_hdr_data = rc_hdr_q;
  assign rc_wvb_data = rc_wvb_q;
  assign dpram_run   = dpram_run_q;
  assign dpram_len   = dpram_len_q;
  assign evt_cnt     = evt_cnt_q;
  // Waiting to start a fill because the DPRAM is still occupied.
  assign stall       = (state_q == ST_RUN) && dpram_busy;

endmodule
